// File: rtl/game_sequencer_if.sv
// Control/status bundle between the game sequencer and the rest of the game.
// The sequencer sits on the slave side; the master side drives frame/start/miss
// events and consumes the ball control, score and state outputs.
interface game_sequencer_if;
    logic       frame_tick;
    logic       start;
    logic       miss_left;
    logic       miss_right;
    logic       ball_run;
    logic       ball_load;
    logic       serve_dir;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       game_over;
    logic       winner;
    logic [2:0] state;

    modport master (
        output frame_tick, start, miss_left, miss_right,
        input  ball_run, ball_load, serve_dir, score1, score2,
               game_over, winner, state
    );

    modport slave (
        input  frame_tick, start, miss_left, miss_right,
        output ball_run, ball_load, serve_dir, score1, score2,
               game_over, winner, state
    );
endinterface

// File: rtl/game_sequencer.sv
// Pong-style game sequencer: serve hold, rally, point pause, game over.
// Frame-based timing uses one down-counter reloaded on entry to SERVE/POINT;
// a frame tick landing on the entry cycle is deliberately not counted.
module game_sequencer #(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    game_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [3:0] WIN        = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);
    localparam logic [7:0] POINT_LOAD = 8'(POINT_FRAMES);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] score1_q, score1_d;
    logic [3:0] score2_q, score2_d;
    logic       serve_dir_q, serve_dir_d;
    logic       entry_q, entry_d;    // high during the first cycle spent in a state

    logic count_en;                  // tick that counts toward the current timer
    logic cnt_expire;                // the counted tick that finishes the timer
    logic win_reached;
    logic miss_l_only, miss_r_only, miss_any;

    // Event qualification shared by next-state and datapath logic
    always_comb begin
        count_en    = bus.frame_tick && !entry_q && (cnt_q != 8'd0);
        cnt_expire  = count_en && (cnt_q == 8'd1);
        win_reached = (score1_q == WIN) || (score2_q == WIN);
        miss_l_only = bus.miss_left  && !bus.miss_right;
        miss_r_only = bus.miss_right && !bus.miss_left;
        miss_any    = bus.miss_left  || bus.miss_right;
    end

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start)  state_d = S_SERVE;
            S_SERVE: if (cnt_expire) state_d = S_PLAY;
            S_PLAY:  if (miss_any)   state_d = S_POINT;
            S_POINT: if (cnt_expire) state_d = win_reached ? S_OVER : S_SERVE;
            S_OVER:  if (bus.start)  state_d = S_SERVE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Datapath registers: frame counter, scores, serve direction, entry flag
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_q       <= 8'd0;
            score1_q    <= 4'd0;
            score2_q    <= 4'd0;
            serve_dir_q <= 1'b0;
            entry_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            serve_dir_q <= serve_dir_d;
            entry_q     <= entry_d;
        end
    end

    // Datapath next-state: counter reload/decrement and score bookkeeping
    always_comb begin
        cnt_d       = cnt_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        serve_dir_d = serve_dir_q;
        entry_d     = (state_d != state_q);

        if (state_d != state_q) begin
            if (state_d == S_SERVE)      cnt_d = SERVE_LOAD;
            else if (state_d == S_POINT) cnt_d = POINT_LOAD;
        end else if (count_en) begin
            cnt_d = cnt_q - 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    score1_d = 4'd0;
                    score2_d = 4'd0;
                end
            end
            S_PLAY: begin
                // Serve goes toward the player who conceded; a double miss replays
                if (miss_l_only) begin
                    if (score2_q < WIN) score2_d = score2_q + 4'd1;
                    serve_dir_d = 1'b0;
                end else if (miss_r_only) begin
                    if (score1_q < WIN) score1_d = score1_q + 4'd1;
                    serve_dir_d = 1'b1;
                end
            end
            S_OVER: begin
                if (bus.start) begin
                    score1_d    = 4'd0;
                    score2_d    = 4'd0;
                    serve_dir_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        bus.ball_run  = (state_q == S_PLAY);
        bus.ball_load = (state_q == S_SERVE) && entry_q;
        bus.serve_dir = serve_dir_q;
        bus.score1    = score1_q;
        bus.score2    = score2_q;
        bus.game_over = (state_q == S_OVER);
        bus.winner    = (state_q == S_OVER) && (score2_q == WIN);
        bus.state     = state_q;
    end

endmodule
